bus_sync_qual: RTL and testbench
================================

Name: bus_sync_qual

Overview:
Parametrised multi-bit CDC bus synchroniser with a programmable stability qualifier. bus_in is a slow-changing bus from a foreign clock domain. It passes through an N-stage flop chain into dest_clk. The synchronised value is published on bus_sync only after it has held the same value for a configurable number of consecutive dest_clk cycles. Adds update strobe, settled flag, update freeze and a saturating glitch (rejected-candidate) counter for debug/status registers.

Parameters:
BUS_BW, 8, bus width in bits (>=1)
SYNC_STAGES, 2, synchroniser flop depth (>=2)
STABLE_CNT, 1, consecutive equal compares required before publishing (>=1); SYNC_STAGES=2/STABLE_CNT=1 gives the legacy 2-level qualifier timing
GLITCH_W, 8, glitch counter width (>=1)

Ports:
dest_clk  input  1  destination clock; all logic on rising edge
dest_rstn  input  1  asynchronous active-low reset, dest_clk domain
bus_in  input  BUS_BW  asynchronous source bus; no timing relation to dest_clk
sync_hold  input  1  dest-domain freeze; 1 blocks bus_sync updates
glitch_clr  input  1  dest-domain synchronous clear of glitch_cnt
bus_sync  output  BUS_BW  qualified, published bus value
bus_update  output  1  one-cycle pulse, high the cycle after bus_sync changed value
bus_settled  output  1  1 = current sampled value has met the stability qualifier
glitch_cnt  output  GLITCH_W  saturating count of candidates abandoned before qualifying

Behaviour:
- Reset: dest_rstn is asynchronous, active-low; clock is dest_clk. While low: sync chain s[0..SYNC_STAGES-1]=0, prev=0, bus_sync=0, bus_update=0, glitch_cnt=0, stab counter cnt=STABLE_CNT (settled), bus_settled=1. Reset mid-operation discards any pending candidate; no update pulse on reset exit.
- Chain: s[0]<=bus_in, s[i]<=s[i-1]; samp=s[SYNC_STAGES-1]; prev<=samp each cycle. Only s[0] may go metastable; no logic reads s[0..SYNC_STAGES-2].
- eq = (samp==prev), full-bus compare.
- cnt, width clog2(STABLE_CNT+1): if !eq, cnt<=0; else if cnt<STABLE_CNT, cnt<=cnt+1; else hold (saturate).
- qualified = eq && (cnt >= STABLE_CNT-1). bus_settled = registered: 1 when cnt==STABLE_CNT.
- Publish: if qualified && !sync_hold && (samp != bus_sync), bus_sync<=samp and bus_update<=1; else bus_update<=0. Equal values never pulse bus_update.
- Latency: bus_in changes before edge 1 and then holds. bus_sync takes the new value at edge SYNC_STAGES+1+STABLE_CNT and bus_update is high for the following cycle. Example: defaults give edge 4; SYNC_STAGES=3/STABLE_CNT=4 gives edge 8.
- sync_hold: while 1, bus_sync is frozen and cnt/glitch logic keeps running. On release with the sample already qualified, bus_sync updates at the first edge where sync_hold=0. A value that came and went entirely during the hold is never published.
- Glitch: when !eq && cnt<STABLE_CNT, glitch_cnt<=glitch_cnt+1, saturating at all-ones. A change arriving while settled (cnt==STABLE_CNT) is a normal transition and is not counted. glitch_clr has priority over a same-cycle increment (result 0).
- Bus skew: a multi-bit transition sampled as intermediate codes is filtered by the qualifier. Intermediate codes lasting fewer than STABLE_CNT+1 samples are never published and count as glitches.
- Constraint: source must hold each value at least SYNC_STAGES+STABLE_CNT+1 dest cycles to guarantee publication. Faster toggling may be suppressed indefinitely; this is by design.
- Illegal parameters (SYNC_STAGES<2, STABLE_CNT<1) are rejected by an elaboration-time check.

Test Plan:
- Defaults, reset then bus_in 0x00->0xA5 held -> bus_sync=0xA5 at edge 4, bus_update high 1 cycle, glitch_cnt=0, bus_settled 0 then back to 1.
- SYNC_STAGES=3, STABLE_CNT=4, bus_in 0x00->0x3C held -> bus_sync changes at edge 8. bus_in then 0x3C->0x11 for 3 cycles->0x3C -> bus_sync stays 0x3C, no bus_update, glitch_cnt increments by 1.
- Defaults, bus_in toggles 0x55/0xAA every dest cycle for 20 cycles -> bus_sync unchanged, glitch_cnt counts each abandoned candidate. GLITCH_W=2 -> saturates at 3. glitch_clr coincident with an increment -> 0.
- sync_hold=1, bus_in 0x00->0x7E held 10 cycles -> bus_sync=0x00. Drop sync_hold -> bus_sync=0x7E on next edge, single bus_update pulse.
- bus_in 0x00->0xFF, assert dest_rstn low asynchronously mid-qualification -> all outputs return to reset values immediately. Release with bus_in=0xFF -> publication follows full latency from reset exit, no stale pulse.
- bus_in rewritten with the same value 0x5A repeatedly -> bus_update never pulses, glitch_cnt stays 0.

Source files
------------

// File: rtl/bus_sync_qual.sv
// Multi-bit CDC bus synchroniser: an N-flop chain into dest_clk followed by a
// stability qualifier that publishes a sample only after it has held steady.
module bus_sync_qual #(
  parameter int BUS_BW      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CNT  = 1,
  parameter int GLITCH_W    = 8
) (
  input  logic                dest_clk,
  input  logic                dest_rstn,
  input  logic [BUS_BW-1:0]   bus_in,
  input  logic                sync_hold,
  input  logic                glitch_clr,
  output logic [BUS_BW-1:0]   bus_sync,
  output logic                bus_update,
  output logic                bus_settled,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

  if (SYNC_STAGES < 2 || STABLE_CNT < 1 || BUS_BW < 1 || GLITCH_W < 1) begin : g_param_check
    $error("bus_sync_qual: illegal parameters (need SYNC_STAGES>=2, STABLE_CNT>=1, BUS_BW>=1, GLITCH_W>=1)");
  end

  // sync_q[0] is the only flop allowed to go metastable; only the last stage is read.
  logic [SYNC_STAGES-1:0][BUS_BW-1:0] sync_q;
  logic [BUS_BW-1:0]   prev_q;
  logic [BUS_BW-1:0]   bus_sync_q, bus_sync_d;
  logic                update_q, update_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                settled_q, settled_d;
  logic [GLITCH_W-1:0] glitch_q, glitch_d;

  logic [BUS_BW-1:0] samp;
  logic              eq;
  logic [CNT_W:0]    cnt_inc;
  logic              qualified;
  logic              glitch_evt;

  assign samp    = sync_q[SYNC_STAGES-1];
  assign eq      = (samp == prev_q);
  assign cnt_inc = {1'b0, cnt_q} + 1'b1;

  // Equivalent to cnt >= STABLE_CNT-1, written one bit wider so it never
  // degenerates into an unsigned compare against zero.
  assign qualified  = eq && (cnt_inc >= (CNT_W + 1)'(STABLE_CNT));
  assign glitch_evt = !eq && (cnt_q < CNT_MAX);

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    cnt_d      = cnt_q;
    bus_sync_d = bus_sync_q;
    update_d   = 1'b0;
    glitch_d   = glitch_q;

    if (!eq) begin
      cnt_d = '0;
    end else if (cnt_q < CNT_MAX) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
    settled_d = (cnt_d == CNT_MAX);

    if (qualified && !sync_hold && (samp != bus_sync_q)) begin
      bus_sync_d = samp;
      update_d   = 1'b1;
    end

    if (glitch_clr) begin
      glitch_d = '0;
    end else if (glitch_evt && (glitch_q != '1)) begin
      glitch_d = glitch_q + 1'b1;
    end
  end

  // Reset leaves the qualifier settled on an all-zero history, so leaving reset
  // can never produce an update pulse.
  always_ff @(posedge dest_clk or negedge dest_rstn) begin
    if (!dest_rstn) begin
      // NOTE: the synchroniser chain is reset too; it is a handful of flops, not
      // a RAM, and a known zero history keeps reset exit free of stale pulses.
      sync_q     <= '0;
      prev_q     <= '0;
      cnt_q      <= CNT_MAX;
      settled_q  <= 1'b1;
      bus_sync_q <= '0;
      update_q   <= 1'b0;
      glitch_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values,
      // which is what makes the chain shift by exactly one stage per clock.
      sync_q     <= {sync_q[SYNC_STAGES-2:0], bus_in};
      prev_q     <= samp;
      cnt_q      <= cnt_d;
      settled_q  <= settled_d;
      bus_sync_q <= bus_sync_d;
      update_q   <= update_d;
      glitch_q   <= glitch_d;
    end
  end

  assign bus_sync    = bus_sync_q;
  assign bus_update  = update_q;
  assign bus_settled = settled_q;
  assign glitch_cnt  = glitch_q;

endmodule

// File: tb/tb_bus_sync_qual.sv
// Bench for bus_sync_qual: three configurations share one stimulus stream and are
// checked every cycle against a run-length model of the sampled bus.
module tb_bus_sync_qual;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] bus_in = 8'h00;
  logic       sync_hold = 1'b0;
  logic       glitch_clr = 1'b0;
  logic       chk_en = 1'b0;

  logic [7:0] def_sync, deep_sync, g2_sync;
  logic       def_upd, deep_upd, g2_upd;
  logic       def_set, deep_set, g2_set;
  logic [7:0] def_glitch, deep_glitch;
  logic [1:0] g2_glitch;

  int total = 0;
  int bad = 0;
  int pulses_def = 0;
  int pulses_deep = 0;

  // Instance 0: defaults, 1: SYNC_STAGES=3/STABLE_CNT=4, 2: GLITCH_W=2.
  bus_sync_qual u_def (
    .dest_clk(clk), .dest_rstn(rst_n), .bus_in(bus_in), .sync_hold(sync_hold),
    .glitch_clr(glitch_clr), .bus_sync(def_sync), .bus_update(def_upd),
    .bus_settled(def_set), .glitch_cnt(def_glitch));

  bus_sync_qual #(.BUS_BW(8), .SYNC_STAGES(3), .STABLE_CNT(4), .GLITCH_W(8)) u_deep (
    .dest_clk(clk), .dest_rstn(rst_n), .bus_in(bus_in), .sync_hold(sync_hold),
    .glitch_clr(glitch_clr), .bus_sync(deep_sync), .bus_update(deep_upd),
    .bus_settled(deep_set), .glitch_cnt(deep_glitch));

  bus_sync_qual #(.BUS_BW(8), .SYNC_STAGES(2), .STABLE_CNT(1), .GLITCH_W(2)) u_g2 (
    .dest_clk(clk), .dest_rstn(rst_n), .bus_in(bus_in), .sync_hold(sync_hold),
    .glitch_clr(glitch_clr), .bus_sync(g2_sync), .bus_update(g2_upd),
    .bus_settled(g2_set), .glitch_cnt(g2_glitch));

  initial forever #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A sample is publishable once it has been seen STABLE_CNT+1 times in a row;
  // a change that ends a run shorter than that is a glitch.
  int    ss [3] = '{2, 3, 2};
  int    sc [3] = '{1, 4, 1};
  int    gw [3] = '{8, 8, 2};
  string nm [3] = '{"def", "deep", "g2"};

  logic [7:0] pipe [3][8];
  int         run_len [3];
  int         run_prev [3];
  logic [7:0] m_sync [3];
  logic       m_upd [3];
  logic       m_set [3];
  int         m_glitch [3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 8; i++) pipe[k][i] = 8'h00;
      run_len[k]  = 1000;
      run_prev[k] = 1000;
      m_sync[k]   = 8'h00;
      m_upd[k]    = 1'b0;
      m_set[k]    = 1'b1;
      m_glitch[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    logic [7:0] samp, nsamp;
    bit qual, glt;
    samp = pipe[k][ss[k]-1];
    qual = (run_len[k] >= sc[k] + 1);
    glt  = (run_len[k] == 1) && (run_prev[k] < sc[k] + 1);
    m_set[k] = qual;
    if (qual && !sync_hold && (samp != m_sync[k])) begin
      m_sync[k] = samp;
      m_upd[k]  = 1'b1;
    end else begin
      m_upd[k] = 1'b0;
    end
    if (glitch_clr) m_glitch[k] = 0;
    else if (glt && (m_glitch[k] < (1 << gw[k]) - 1)) m_glitch[k] = m_glitch[k] + 1;
    for (int i = ss[k] - 1; i > 0; i--) pipe[k][i] = pipe[k][i-1];
    pipe[k][0] = bus_in;
    nsamp = pipe[k][ss[k]-1];
    run_prev[k] = run_len[k];
    run_len[k]  = (nsamp == samp) ? run_len[k] + 1 : 1;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset();
    else for (int k = 0; k < 3; k++) model_step(k);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int k, input logic [7:0] s, input logic u, input logic st,
                     input logic [7:0] g);
    check({nm[k], ".bus_sync"},    32'(s),  32'(m_sync[k]));
    check({nm[k], ".bus_update"},  32'(u),  32'(m_upd[k]));
    check({nm[k], ".bus_settled"}, 32'(st), 32'(m_set[k]));
    check({nm[k], ".glitch_cnt"},  32'(g),  32'(m_glitch[k]));
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      cmp(0, def_sync, def_upd, def_set, def_glitch);
      cmp(1, deep_sync, deep_upd, deep_set, deep_glitch);
      cmp(2, g2_sync, g2_upd, g2_set, {6'b0, g2_glitch});
    end
  end

  // Advances n edges, counting update pulses; ends 2 time units after an edge.
  task automatic hold_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      pulses_def  += int'(def_upd);
      pulses_deep += int'(deep_upd);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rv;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset def.bus_sync",    32'(def_sync),   32'h00);
    check("reset def.bus_update",  32'(def_upd),    32'h0);
    check("reset def.bus_settled", 32'(def_set),    32'h1);
    check("reset def.glitch_cnt",  32'(def_glitch), 32'h00);
    check("reset deep.bus_settled", 32'(deep_set),  32'h1);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    hold_cycles(3);

    // Basic latency: defaults publish at edge 4, deep config at edge 8.
    bus_in = 8'hA5;
    for (int e = 1; e <= 10; e++) begin
      @(posedge clk);
      #1;
      if (e == 3) begin
        check("a5 def sync e3", 32'(def_sync), 32'h00);
        check("a5 def settled e3", 32'(def_set), 32'h0);
      end
      if (e == 4) begin
        check("a5 def sync e4", 32'(def_sync), 32'hA5);
        check("a5 def update e4", 32'(def_upd), 32'h1);
        check("a5 def settled e4", 32'(def_set), 32'h1);
      end
      if (e == 5) check("a5 def update e5", 32'(def_upd), 32'h0);
      if (e == 7) check("a5 deep sync e7", 32'(deep_sync), 32'h00);
      if (e == 8) begin
        check("a5 deep sync e8", 32'(deep_sync), 32'hA5);
        check("a5 deep update e8", 32'(deep_upd), 32'h1);
      end
      if (e == 10) check("a5 def glitch", 32'(def_glitch), 32'h00);
      #1;
    end

    // Short excursion to 0x11 for 3 cycles is rejected by the deep qualifier.
    bus_in = 8'h3C;
    hold_cycles(12);
    pulses_deep = 0;
    bus_in = 8'h11;
    hold_cycles(3);
    bus_in = 8'h3C;
    hold_cycles(12);
    check("excursion deep pulses", 32'(pulses_deep), 32'd0);
    check("excursion deep sync", 32'(deep_sync), 32'h3C);
    check("excursion deep glitch", 32'(deep_glitch), 32'd1);

    // Fast toggling: never published, every abandoned candidate counted.
    glitch_clr = 1'b1;
    hold_cycles(1);
    glitch_clr = 1'b0;
    check("clr def glitch", 32'(def_glitch), 32'd0);
    pulses_def = 0;
    for (int i = 0; i < 20; i++) begin
      bus_in = (i % 2 == 1) ? 8'hAA : 8'h55;
      hold_cycles(1);
    end
    bus_in = 8'h3C;
    hold_cycles(10);
    check("toggle def glitch", 32'(def_glitch), 32'd20);
    check("toggle deep glitch", 32'(deep_glitch), 32'd20);
    check("toggle g2 saturate", 32'(g2_glitch), 32'd3);
    check("toggle def sync", 32'(def_sync), 32'h3C);
    check("toggle def pulses", 32'(pulses_def), 32'd0);

    // glitch_clr on a cycle that also carries an increment wins.
    for (int i = 0; i < 10; i++) begin
      bus_in = (i % 2 == 1) ? 8'hAA : 8'h55;
      glitch_clr = (i == 5);
      @(posedge clk);
      #1;
      if (i == 5) begin
        check("clr+inc def", 32'(def_glitch), 32'd0);
        check("clr+inc deep", 32'(deep_glitch), 32'd0);
        check("clr+inc g2", 32'(g2_glitch), 32'd0);
      end
      if (i == 6) begin
        check("after clr def", 32'(def_glitch), 32'd1);
        check("after clr deep", 32'(deep_glitch), 32'd1);
      end
      #1;
    end
    glitch_clr = 1'b0;
    bus_in = 8'h3C;
    hold_cycles(10);

    // Freeze: values arriving under sync_hold wait; a transient one is lost.
    bus_in = 8'h00;
    hold_cycles(12);
    sync_hold = 1'b1;
    bus_in = 8'h33;
    hold_cycles(12);
    bus_in = 8'h7E;
    hold_cycles(12);
    check("hold def sync frozen", 32'(def_sync), 32'h00);
    check("hold deep sync frozen", 32'(deep_sync), 32'h00);
    pulses_def = 0;
    pulses_deep = 0;
    sync_hold = 1'b0;
    hold_cycles(1);
    check("release def sync", 32'(def_sync), 32'h7E);
    check("release def update", 32'(def_upd), 32'h1);
    check("release deep sync", 32'(deep_sync), 32'h7E);
    hold_cycles(4);
    check("release def pulses", 32'(pulses_def), 32'd1);
    check("release deep pulses", 32'(pulses_deep), 32'd1);

    // Asynchronous reset in the middle of a qualification.
    bus_in = 8'hFF;
    hold_cycles(2);
    #1 rst_n = 1'b0;
    #1;
    check("async rst def sync", 32'(def_sync), 32'h00);
    check("async rst def update", 32'(def_upd), 32'h0);
    check("async rst def settled", 32'(def_set), 32'h1);
    check("async rst deep sync", 32'(deep_sync), 32'h00);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      @(posedge clk);
      #1;
      if (e == 3) check("rst exit def sync e3", 32'(def_sync), 32'h00);
      if (e == 4) begin
        check("rst exit def sync e4", 32'(def_sync), 32'hFF);
        check("rst exit def update e4", 32'(def_upd), 32'h1);
      end
      if (e == 7) check("rst exit deep sync e7", 32'(deep_sync), 32'h00);
      if (e == 8) check("rst exit deep sync e8", 32'(deep_sync), 32'hFF);
      #1;
    end

    // Rewriting the same value never pulses and never counts.
    bus_in = 8'h5A;
    hold_cycles(12);
    glitch_clr = 1'b1;
    hold_cycles(1);
    glitch_clr = 1'b0;
    pulses_def = 0;
    pulses_deep = 0;
    for (int i = 0; i < 15; i++) begin
      bus_in = 8'h5A;
      hold_cycles(1);
    end
    check("same def pulses", 32'(pulses_def), 32'd0);
    check("same deep pulses", 32'(pulses_deep), 32'd0);
    check("same def glitch", 32'(def_glitch), 32'd0);

    // Randomised segments of varying length, with occasional freeze and clear.
    rv = 8'h5A;
    for (int seg = 0; seg < 110; seg++) begin
      if ($urandom_range(0, 3) != 0) rv = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 2) == 0) rv = {4'h0, rv[3:0] & 4'h3};
      bus_in = rv;
      sync_hold = ($urandom_range(0, 7) == 0);
      for (int c = 0, n = int'($urandom_range(1, 9)); c < n; c++) begin
        glitch_clr = ($urandom_range(0, 31) == 0);
        hold_cycles(1);
      end
    end
    sync_hold = 1'b0;
    glitch_clr = 1'b0;
    hold_cycles(12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
